// File: rtl/symbol_stream_gen.sv
// Game-round symbol source: emits LFSR-derived 2-bit symbols at a fixed cadence
// between start/stop pulses and keeps a saturating count of target-symbol hits.
module symbol_stream_gen #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk100M,
  input  logic       RstN,
  input  logic       startGen,
  input  logic       stopGen,
  output logic       busy,
  output logic       symValid,
  output logic [1:0] symCode,
  output logic [1:0] targetSym,
  output logic [7:0] targetCount,
  output logic       done
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic             busy_q;
  logic             sym_valid_q;
  logic [1:0]       sym_code_q;
  logic [1:0]       target_sym_q;
  logic [7:0]       target_count_q;
  logic             done_q;
  logic             tick;

  // Galois right shift for x^16+x^14+x^13+x^11+1.
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign tick   = (state_q == S_RUN) && (div_q == DIV_LAST);

  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      lfsr_q         <= LFSR_SEED;
      busy_q         <= 1'b0;
      sym_valid_q    <= 1'b0;
      sym_code_q     <= 2'd0;
      target_sym_q   <= 2'd0;
      target_count_q <= 8'd0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          lfsr_q      <= lfsr_d;
          done_q      <= 1'b0;
          sym_valid_q <= 1'b0;
          if (startGen) begin
            state_q        <= S_RUN;
            target_sym_q   <= lfsr_q[3:2];
            target_count_q <= 8'd0;
            div_q          <= '0;
            busy_q         <= 1'b1;
          end
        end
        S_RUN: begin
          // Stop outranks a coincident tick: no strobe, count or LFSR step.
          if (stopGen) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            div_q       <= '0;
          end else if (tick) begin
            div_q       <= '0;
            sym_valid_q <= 1'b1;
            sym_code_q  <= lfsr_q[1:0];
            lfsr_q      <= lfsr_d;
            if ((lfsr_q[1:0] == target_sym_q) && (target_count_q != 8'hFF)) begin
              target_count_q <= target_count_q + 8'd1;
            end
          end else begin
            div_q       <= div_q + DIV_W'(1);
            sym_valid_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b1;
          sym_valid_q <= 1'b0;
          lfsr_q      <= lfsr_d;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign symValid    = sym_valid_q;
  assign symCode     = sym_code_q;
  assign targetSym   = target_sym_q;
  assign targetCount = target_count_q;
  assign done        = done_q;

endmodule
